bp_fe_mem_arbiter: RTL and testbench



---
 rtl/bp_fe_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_bp_fe_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_mem_arbiter.sv
// Shares the I$/ITLB command port between the PC generator (req0) and an auxiliary
// engine (req1), and routes each memory response back to the requester that issued it.
module bp_fe_mem_arbiter #(
   parameter int unsigned mem_cmd_width_p  = 128,
   parameter int unsigned mem_resp_width_p = 96,
   parameter int unsigned resp_latency_p   = 2,
   parameter int unsigned starve_limit_p   = 8
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [mem_cmd_width_p-1:0]  r0_cmd_i,
   input  logic                        r0_cmd_v_i,
   output logic                        r0_cmd_yumi_o,
   input  logic                        r0_poison_i,
   output logic [mem_resp_width_p-1:0] r0_resp_o,
   output logic                        r0_resp_v_o,
   input  logic [mem_cmd_width_p-1:0]  r1_cmd_i,
   input  logic                        r1_cmd_v_i,
   input  logic                        r1_lock_i,
   output logic                        r1_cmd_yumi_o,
   output logic                        r1_locked_o,
   output logic [mem_resp_width_p-1:0] r1_resp_o,
   output logic                        r1_resp_v_o,
   output logic [mem_cmd_width_p-1:0]  mem_cmd_o,
   output logic                        mem_cmd_v_o,
   input  logic                        mem_cmd_yumi_i,
   output logic                        mem_poison_o,
   input  logic [mem_resp_width_p-1:0] mem_resp_i,
   input  logic                        mem_resp_v_i,
   output logic                        busy_o,
   output logic                        err_o
);

   localparam int unsigned lat_lp      = resp_latency_p;
   localparam int unsigned starve_w_lp = 8;
   localparam int unsigned ign_w_lp    = 3;

   localparam logic [1:0] e_fetch = 2'd0;
   localparam logic [1:0] e_drain = 2'd1;
   localparam logic [1:0] e_lock  = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [starve_w_lp-1:0] starve_q, starve_d;
   logic [lat_lp-1:0]      v_q, v_d;
   logic [lat_lp-1:0]      own_q, own_d;
   logic [lat_lp-1:0]      kill_q, kill_d, kill_eff;
   logic                   err_q, err_d;
   logic [ign_w_lp-1:0]    ign_q, ign_d;

   logic grant0, grant1;
   logic lock_req, starved;
   logic cmd_v, accept;
   logic poison_hit;
   logic tail_v, tail_own, tail_kill, resp_hit;

   assign lock_req = r1_lock_i & r1_cmd_v_i;
   assign starved  = (starve_q == starve_w_lp'(starve_limit_p)) & r1_cmd_v_i;

   // Grant selection and state transitions
   always_comb begin
      state_d = state_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      case (state_q)
         e_fetch: begin
            if (lock_req)        state_d = e_drain;
            else if (starved)    grant1  = 1'b1;
            else if (r0_cmd_v_i) grant0  = 1'b1;
            else                 grant1  = 1'b1;
         end
         e_drain: begin
            if (~|v_q) state_d = e_lock;
         end
         e_lock: begin
            grant1 = 1'b1;
            if (!r1_lock_i) state_d = e_fetch;
         end
         default: state_d = e_fetch;
      endcase
   end

   assign cmd_v         = ~reset_i & ((grant0 & r0_cmd_v_i) | (grant1 & r1_cmd_v_i));
   assign accept        = cmd_v & mem_cmd_yumi_i;
   assign mem_cmd_v_o   = cmd_v;
   assign mem_cmd_o     = reset_i ? '0 : (grant1 ? r1_cmd_i : r0_cmd_i);
   assign r0_cmd_yumi_o = accept & grant0;
   assign r1_cmd_yumi_o = accept & grant1;

   // Poison only ever targets an owner-0 command accepted in the previous cycle
   assign poison_hit   = ~reset_i & r0_poison_i & v_q[0] & ~own_q[0];
   assign mem_poison_o = poison_hit;

   // In-flight shift register; stage 0 is newest, stage lat_lp-1 is the tail
   always_comb begin
      kill_eff    = kill_q;
      kill_eff[0] = kill_q[0] | poison_hit;
      v_d         = '0;
      own_d       = '0;
      kill_d      = '0;
      v_d[0]      = accept;
      own_d[0]    = grant1;
      for (int i = 1; i < int'(lat_lp); i++) begin
         v_d[i]    = v_q[i-1];
         own_d[i]  = own_q[i-1];
         kill_d[i] = kill_eff[i-1];
      end
   end

   assign tail_v    = v_q[lat_lp-1];
   assign tail_own  = own_q[lat_lp-1];
   assign tail_kill = kill_eff[lat_lp-1];
   assign resp_hit  = ~reset_i & mem_resp_v_i & tail_v & ~tail_kill;

   assign r0_resp_v_o = resp_hit & ~tail_own;
   assign r1_resp_v_o = resp_hit & tail_own;
   assign r0_resp_o   = reset_i ? '0 : mem_resp_i;
   assign r1_resp_o   = reset_i ? '0 : mem_resp_i;

   // Orphan responses are errors, except stragglers from before the last reset
   always_comb begin
      err_d    = err_q | (mem_resp_v_i & ~tail_v & (ign_q == '0));
      ign_d    = (ign_q == '0) ? '0 : ign_q - ign_w_lp'(1);
      starve_d = starve_q;
      if (r1_cmd_yumi_o)
         starve_d = '0;
      else if (r1_cmd_v_i && (starve_q < starve_w_lp'(starve_limit_p)))
         starve_d = starve_q + starve_w_lp'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= e_fetch;
         starve_q <= '0;
         v_q      <= '0;
         own_q    <= '0;
         kill_q   <= '0;
         err_q    <= 1'b0;
         ign_q    <= ign_w_lp'(resp_latency_p);
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         v_q      <= v_d;
         own_q    <= own_d;
         kill_q   <= kill_d;
         err_q    <= err_d;
         ign_q    <= ign_d;
      end
   end

   assign busy_o      = |v_q;
   assign err_o       = err_q;
   assign r1_locked_o = (state_q == e_lock);

endmodule

// File: tb/tb_bp_fe_mem_arbiter.sv
// Directed bench for bp_fe_mem_arbiter: priority/starvation, poison, response routing,
// lock sequencing, orphan-response error and asynchronous reset.
module tb_bp_fe_mem_arbiter;

   logic         clk_i;
   logic         reset_i;
   logic [127:0] r0_cmd_i, r1_cmd_i, mem_cmd_o;
   logic         r0_cmd_v_i, r0_cmd_yumi_o, r0_poison_i, r0_resp_v_o;
   logic         r1_cmd_v_i, r1_lock_i, r1_cmd_yumi_o, r1_locked_o, r1_resp_v_o;
   logic [95:0]  r0_resp_o, r1_resp_o, mem_resp_i;
   logic         mem_cmd_v_o, mem_cmd_yumi_i, mem_poison_o, mem_resp_v_i;
   logic         busy_o, err_o;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] cmd_a = 128'hA0A0_0000_1111_2222_3333_4444_5555_AAAA;
   localparam logic [127:0] cmd_b = 128'hB0B0_0000_6666_7777_8888_9999_CCCC_BBBB;
   localparam logic [95:0]  dat0  = 96'hD000_1234_5678_9ABC_DEF0_0001;
   localparam logic [95:0]  dat1  = 96'hD111_CAFE_F00D_BEEF_0BAD_0002;
   localparam logic [95:0]  dat2  = 96'hD222_0F0F_F0F0_5A5A_A5A5_0003;

   bp_fe_mem_arbiter #(
      .mem_cmd_width_p(128), .mem_resp_width_p(96), .resp_latency_p(2), .starve_limit_p(8)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .r0_cmd_i(r0_cmd_i), .r0_cmd_v_i(r0_cmd_v_i), .r0_cmd_yumi_o(r0_cmd_yumi_o),
      .r0_poison_i(r0_poison_i), .r0_resp_o(r0_resp_o), .r0_resp_v_o(r0_resp_v_o),
      .r1_cmd_i(r1_cmd_i), .r1_cmd_v_i(r1_cmd_v_i), .r1_lock_i(r1_lock_i),
      .r1_cmd_yumi_o(r1_cmd_yumi_o), .r1_locked_o(r1_locked_o),
      .r1_resp_o(r1_resp_o), .r1_resp_v_o(r1_resp_v_o),
      .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
      .mem_poison_o(mem_poison_o), .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic idle();
      r0_cmd_i = '0; r0_cmd_v_i = 1'b0; r0_poison_i = 1'b0;
      r1_cmd_i = '0; r1_cmd_v_i = 1'b0; r1_lock_i = 1'b0;
      mem_cmd_yumi_i = 1'b0; mem_resp_i = '0; mem_resp_v_i = 1'b0;
   endtask

   // Inputs change on the falling edge; checks run 1ns later, well before the rising edge
   task automatic step();
      @(negedge clk_i);
      idle();
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      idle();
      reset_i = 1'b1;
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      r0_cmd_i = cmd_a; r0_cmd_v_i = 1'b1; mem_cmd_yumi_i = 1'b1;
      mem_resp_i = dat0; mem_resp_v_i = 1'b1;
      reset_i = 1'b1;
      #1;
      checks++; if (mem_cmd_o !== '0) begin errors++; $display("FAIL reset_mem_cmd got %h exp 0", mem_cmd_o); end
      checks++; if (r0_resp_o !== '0) begin errors++; $display("FAIL reset_r0_resp got %h exp 0", r0_resp_o); end
      checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_v got %b exp 0", mem_cmd_v_o); end
      checks++; if (r0_cmd_yumi_o !== 1'b0) begin errors++; $display("FAIL reset_r0_yumi got %b exp 0", r0_cmd_yumi_o); end
      @(negedge clk_i);
      #1;
      checks++; if ({busy_o, err_o, r1_locked_o, r0_resp_v_o} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {busy_o, err_o, r1_locked_o, r0_resp_v_o}); end
      idle();
      reset_i = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_starvation();
      logic exp1;
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk_i);
         r0_cmd_i = cmd_a; r0_cmd_v_i = 1'b1;
         r1_cmd_i = cmd_b; r1_cmd_v_i = 1'b1;
         mem_cmd_yumi_i = 1'b1;
         #1;
         exp1 = (i == 9);
         checks++; if (r0_cmd_yumi_o !== ~exp1) begin errors++; $display("FAIL starve_r0_yumi cycle %0d got %b exp %b", i, r0_cmd_yumi_o, ~exp1); end
         checks++; if (r1_cmd_yumi_o !== exp1) begin errors++; $display("FAIL starve_r1_yumi cycle %0d got %b exp %b", i, r1_cmd_yumi_o, exp1); end
         checks++; if (mem_cmd_o !== (exp1 ? cmd_b : cmd_a)) begin errors++; $display("FAIL starve_cmd cycle %0d got %h", i, mem_cmd_o); end
      end
      repeat (3) step();
   endtask

   task automatic test_poison();
      do_reset();
      @(negedge clk_i);
      r0_poison_i = 1'b1;
      #1;
      checks++; if (mem_poison_o !== 1'b0) begin errors++; $display("FAIL poison_empty got %b exp 0", mem_poison_o); end
      @(negedge clk_i);
      idle();
      r0_cmd_i = cmd_a; r0_cmd_v_i = 1'b1; mem_cmd_yumi_i = 1'b1;
      #1;
      checks++; if (r0_cmd_yumi_o !== 1'b1) begin errors++; $display("FAIL poison_accept got %b exp 1", r0_cmd_yumi_o); end
      step();
      r0_poison_i = 1'b1;
      #1;
      checks++; if (mem_poison_o !== 1'b1) begin errors++; $display("FAIL poison_fwd got %b exp 1", mem_poison_o); end
      step();
      mem_resp_i = dat0; mem_resp_v_i = 1'b1;
      #1;
      checks++; if ({r0_resp_v_o, r1_resp_v_o} !== 2'b00) begin errors++; $display("FAIL poison_resp got %b exp 00", {r0_resp_v_o, r1_resp_v_o}); end
      step();
      #1;
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL poison_err got %b exp 0", err_o); end
      repeat (2) step();
   endtask

   task automatic test_routing();
      do_reset();
      @(negedge clk_i);
      r0_cmd_i = cmd_a; r0_cmd_v_i = 1'b1; mem_cmd_yumi_i = 1'b1;
      step();
      r1_cmd_i = cmd_b; r1_cmd_v_i = 1'b1; mem_cmd_yumi_i = 1'b1;
      #1;
      checks++; if ({r1_cmd_yumi_o, mem_cmd_o} !== {1'b1, cmd_b}) begin errors++; $display("FAIL route_r1_accept got %b %h", r1_cmd_yumi_o, mem_cmd_o); end
      step();
      r0_cmd_i = cmd_a; r0_cmd_v_i = 1'b1; mem_cmd_yumi_i = 1'b1;
      mem_resp_i = dat0; mem_resp_v_i = 1'b1;
      #1;
      checks++; if ({r0_resp_v_o, r1_resp_v_o, r0_resp_o} !== {2'b10, dat0}) begin errors++; $display("FAIL route_resp0 got %b%b %h exp 10 %h", r0_resp_v_o, r1_resp_v_o, r0_resp_o, dat0); end
      step();
      mem_resp_i = dat1; mem_resp_v_i = 1'b1;
      #1;
      checks++; if ({r0_resp_v_o, r1_resp_v_o, r1_resp_o} !== {2'b01, dat1}) begin errors++; $display("FAIL route_resp1 got %b%b %h exp 01 %h", r0_resp_v_o, r1_resp_v_o, r1_resp_o, dat1); end
      step();
      mem_resp_i = dat2; mem_resp_v_i = 1'b1;
      #1;
      checks++; if ({r0_resp_v_o, r1_resp_v_o, r0_resp_o} !== {2'b10, dat2}) begin errors++; $display("FAIL route_resp2 got %b%b %h exp 10 %h", r0_resp_v_o, r1_resp_v_o, r0_resp_o, dat2); end
      step();
      #1;
      checks++; if ({err_o, busy_o} !== 2'b00) begin errors++; $display("FAIL route_idle got err/busy %b exp 00", {err_o, busy_o}); end
   endtask

   task automatic test_lock();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         r0_cmd_i = cmd_a; r0_cmd_v_i = 1'b1; mem_cmd_yumi_i = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         r0_cmd_i = cmd_a; r0_cmd_v_i = 1'b1; mem_cmd_yumi_i = 1'b1;
         r1_cmd_i = cmd_b; r1_cmd_v_i = 1'b1; r1_lock_i = 1'b1;
         #1;
         checks++; if ({mem_cmd_v_o, r0_cmd_yumi_o, r1_cmd_yumi_o, r1_locked_o} !== 4'b0) begin errors++; $display("FAIL lock_drain cycle %0d got v/y0/y1/lk %b exp 0000", i, {mem_cmd_v_o, r0_cmd_yumi_o, r1_cmd_yumi_o, r1_locked_o}); end
      end
      @(negedge clk_i);
      #1;
      checks++; if ({r1_locked_o, r1_cmd_yumi_o, r0_cmd_yumi_o, mem_cmd_o} !== {3'b110, cmd_b}) begin errors++; $display("FAIL lock_grant got lk/y1/y0 %b cmd %h", {r1_locked_o, r1_cmd_yumi_o, r0_cmd_yumi_o}, mem_cmd_o); end
      @(negedge clk_i);
      r1_lock_i = 1'b0; r1_cmd_v_i = 1'b0;
      #1;
      checks++; if ({r1_locked_o, r0_cmd_yumi_o, mem_cmd_v_o} !== 3'b100) begin errors++; $display("FAIL lock_release got lk/y0/v %b exp 100", {r1_locked_o, r0_cmd_yumi_o, mem_cmd_v_o}); end
      @(negedge clk_i);
      #1;
      checks++; if ({r1_locked_o, r0_cmd_yumi_o} !== 2'b01) begin errors++; $display("FAIL lock_resume got lk/y0 %b exp 01", {r1_locked_o, r0_cmd_yumi_o}); end
      repeat (3) step();
   endtask

   task automatic test_orphan_err();
      do_reset();
      @(negedge clk_i);
      mem_resp_i = dat1; mem_resp_v_i = 1'b1;
      #1;
      checks++; if ({r0_resp_v_o, r1_resp_v_o, err_o} !== 3'b000) begin errors++; $display("FAIL orphan_pre got %b exp 000", {r0_resp_v_o, r1_resp_v_o, err_o}); end
      step();
      #1;
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL orphan_err got %b exp 1", err_o); end
      repeat (4) step();
      #1;
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", err_o); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         r0_cmd_i = cmd_a; r0_cmd_v_i = 1'b1; mem_cmd_yumi_i = 1'b1;
      end
      @(negedge clk_i);
      r0_cmd_v_i = 1'b1; mem_cmd_yumi_i = 1'b1;
      #1;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL arst_busy_before got %b exp 1", busy_o); end
      #1;
      reset_i = 1'b1;
      #1;
      checks++; if ({busy_o, mem_cmd_v_o, r0_cmd_yumi_o, err_o} !== 4'b0) begin errors++; $display("FAIL arst_clear got busy/v/y0/err %b exp 0000", {busy_o, mem_cmd_v_o, r0_cmd_yumi_o, err_o}); end
      checks++; if (mem_cmd_o !== '0) begin errors++; $display("FAIL arst_cmd got %h exp 0", mem_cmd_o); end
      @(negedge clk_i);
      idle();
      reset_i = 1'b0;
      mem_resp_i = dat2; mem_resp_v_i = 1'b1;
      #1;
      checks++; if ({r0_resp_v_o, r1_resp_v_o} !== 2'b00) begin errors++; $display("FAIL arst_stray_resp got %b exp 00", {r0_resp_v_o, r1_resp_v_o}); end
      step();
      #1;
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL arst_stray_err got %b exp 0", err_o); end
      step();
   endtask

   initial begin
      reset_i = 1'b1;
      idle();
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
      test_reset();
      test_starvation();
      test_poison();
      test_routing();
      test_lock();
      test_orphan_err();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
